// File: rtl/fft_iter_sequencer.sv
// fft_iter_sequencer - run sequencer and RAM-port arbiter for the iterative radix-2 FFT.
// Optional cycle counter on o_CYCLES when FFT_SEQ_CYCLE_CNT_EN is defined.
module fft_iter_sequencer #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int RD_LAT      = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              i_START,
  input  logic              i_HOST_REQ,
  output logic              o_HOST_GNT,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_ADDR_EN,
  output logic              o_LAY_EN,
  output logic              o_WR,
  output logic              o_FIRST,
  output logic [LayWL-1:0]  o_LAYER,
  output logic [ButtWL-1:0] o_BUTT
`ifdef FFT_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]       o_CYCLES
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_HOST, S_RD, S_WB, S_FIN} state_t;

  state_t            state_q, state_d;
  logic [LayWL-1:0]  layer_q, layer_d;
  logic [ButtWL-1:0] butt_q, butt_d;
  logic [1:0]        rd_q, rd_d;
  logic              last_butt, last_layer, busy;

  assign last_butt  = (butt_q == ButtWL'(BUTTERFLYES - 1));
  assign last_layer = (layer_q == LayWL'(LAYERS - 1));
  assign busy       = (state_q == S_RD) || (state_q == S_WB);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      butt_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      butt_q  <= butt_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    butt_d  = butt_q;
    rd_d    = rd_q;
    if (EN) begin
      case (state_q)
        S_IDLE: begin
          // START has priority over a simultaneous host request
          if (i_START) begin
            state_d = S_RD;
            layer_d = '0;
            butt_d  = '0;
            rd_d    = '0;
          end else if (i_HOST_REQ) begin
            state_d = S_HOST;
          end
        end
        S_HOST: begin
          if (!i_HOST_REQ) state_d = S_IDLE;
        end
        S_RD: begin
          if (rd_q == 2'(RD_LAT - 1)) begin
            rd_d    = '0;
            state_d = S_WB;
          end else begin
            rd_d = rd_q + 2'd1;
          end
        end
        S_WB: begin
          state_d = S_RD;
          if (last_butt) begin
            butt_d = '0;
            if (last_layer) begin
              layer_d = '0;
              state_d = S_FIN;
            end else begin
              layer_d = layer_q + LayWL'(1);
            end
          end else begin
            butt_d = butt_q + ButtWL'(1);
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          layer_d = '0;
          butt_d  = '0;
          rd_d    = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_BUSY     = busy;
    o_HOST_GNT = (state_q == S_HOST);
    o_WR       = EN && (state_q == S_WB);
    o_ADDR_EN  = EN && (state_q == S_WB);
    o_LAY_EN   = EN && (state_q == S_WB) && last_butt;
    o_DONE     = EN && (state_q == S_FIN);
    o_FIRST    = busy && (layer_q == LayWL'(0));
  end

  assign o_LAYER = layer_q;
  assign o_BUTT  = butt_q;

`ifdef FFT_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (EN) begin
      if ((state_q == S_IDLE) && i_START) cyc_d = '0;
      else if (busy && (cyc_q != 32'hFFFF_FFFF)) cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  assign o_CYCLES = cyc_q;
`endif

endmodule
